pwm_capture: RTL and testbench



---
 rtl/pwm_capture.sv | 171 +++++++++++++++++
 tb/tb_pwm_capture.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform in prescaler ticks.
//
// Reports the high time and the full period (rising edge to rising edge) of
// each completed cycle with a one-clock valid strobe. If no rising edge
// arrives for TIMEOUT ticks, it reports zero counts once and raises a stuck
// flag for the current input level. The tick convention and count width
// match the team's PWM generator, so generator settings duty d and top t
// measure as high_count = d and period_count = t + 1.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high reset
//   pwm_in       asynchronous PWM input
//   prescaler    clocks per tick (0 behaves as 1), may change at any time
//   high_count   high ticks in the last completed period
//   period_count ticks in the last completed period
//   valid        one-cycle strobe: counts and stuck flags were updated
//   stuck_high   no rising edge for TIMEOUT ticks while the input is high
//   stuck_low    no rising edge for TIMEOUT ticks while the input is low
module pwm_capture #(
    parameter int unsigned W           = 10,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         pwm_in,
    input  logic [31:0]  prescaler,
    output logic [W-1:0] high_count,
    output logic [W-1:0] period_count,
    output logic         valid,
    output logic         stuck_high,
    output logic         stuck_low
);

    localparam logic [W-1:0] AccOne     = W'(1);
    localparam logic [W-1:0] AccMax     = {W{1'b1}};
    localparam logic [W:0]   TimeoutCmp = (W+1)'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StStuck
    } state_e;

    state_e                 state_q;
    logic [31:0]            presc_cnt_q;
    logic [31:0]            presc_max;
    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   prev_q;
    logic                   rise;
    logic [W-1:0]           hi_acc_q;
    logic [W-1:0]           per_acc_q;
    logic [W:0]             per_next;

    // ------------------------------------------------------------------
    // Tick generation. Comparing with >= lets a lowered prescaler take
    // effect immediately instead of waiting for the counter to wrap.
    // ------------------------------------------------------------------
    always_comb begin
        presc_max = (prescaler == 32'd0) ? 32'd0 : prescaler - 32'd1;
        tick      = (presc_cnt_q >= presc_max);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_cnt_q <= 32'd0;
        end else if (tick) begin
            presc_cnt_q <= 32'd0;
        end else begin
            presc_cnt_q <= presc_cnt_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Input synchronizer and edge detector. Everything resets to 1 so an
    // input that is already high when reset releases is not a rising edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else if (tick) begin
            prev_q <= s;
        end
    end

    assign rise = s & ~prev_q;

    // Widened so the timeout compare cannot wrap.
    assign per_next = {1'b0, per_acc_q} + {{W{1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Measurement FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            hi_acc_q     <= '0;
            per_acc_q    <= '0;
            high_count   <= '0;
            period_count <= '0;
            valid        <= 1'b0;
            stuck_high   <= 1'b0;
            stuck_low    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (tick) begin
                case (state_q)
                    StIdle: begin
                        // The first edge only starts a measurement.
                        if (rise) begin
                            hi_acc_q  <= AccOne;
                            per_acc_q <= AccOne;
                            state_q   <= StMeasure;
                        end
                    end
                    StMeasure: begin
                        if (rise) begin
                            high_count   <= hi_acc_q;
                            period_count <= per_acc_q;
                            valid        <= 1'b1;
                            hi_acc_q     <= AccOne;
                            per_acc_q    <= AccOne;
                        end else if (per_next == TimeoutCmp) begin
                            high_count   <= '0;
                            period_count <= '0;
                            valid        <= 1'b1;
                            stuck_high   <= s;
                            stuck_low    <= ~s;
                            state_q      <= StStuck;
                        end else begin
                            // Saturate silently; the timeout reports long gaps.
                            if (per_acc_q != AccMax) begin
                                per_acc_q <= per_acc_q + AccOne;
                            end
                            if (s && (hi_acc_q != AccMax)) begin
                                hi_acc_q <= hi_acc_q + AccOne;
                            end
                        end
                    end
                    StStuck: begin
                        // Recovery edge restarts measurement without a strobe.
                        if (rise) begin
                            stuck_high <= 1'b0;
                            stuck_low  <= 1'b0;
                            hi_acc_q   <= AccOne;
                            per_acc_q  <= AccOne;
                            state_q    <= StMeasure;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a table of periodic waveforms plus
// hand-written sequences for stuck detection, reset and prescaler changes.
module tb_pwm_capture;

    localparam int W = 10;

    logic         clock = 1'b0;
    logic         reset;
    logic         pwm_in;
    logic [31:0]  prescaler;
    logic [W-1:0] high_count;
    logic [W-1:0] period_count;
    logic         valid;
    logic         stuck_high;
    logic         stuck_low;

    pwm_capture #(
        .W           (W),
        .SYNC_STAGES (2),
        .TIMEOUT     (1023)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pwm_in       (pwm_in),
        .prescaler    (prescaler),
        .high_count   (high_count),
        .period_count (period_count),
        .valid        (valid),
        .stuck_high   (stuck_high),
        .stuck_low    (stuck_low)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cyc;
        int hc;
        int pc;
        int sh;
        int sl;
    } ev_t;

    ev_t evq[$];
    int  rq[$];

    // Log every valid strobe with the cycle it appeared in.
    always @(negedge clock) begin
        if (valid === 1'b1) begin
            evq.push_back('{cyc, int'(high_count), int'(period_count),
                            int'(stuck_high), int'(stuck_low)});
        end
        if (stuck_high === 1'b1 && stuck_low === 1'b1) begin
            errors++;
            $display("FAIL flags_exclusive at cycle %0d: both stuck flags high", cyc);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and checks happen 1 time unit after a falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic do_reset(input int presc);
        reset     = 1'b1;
        pwm_in    = 1'b0;
        prescaler = presc;
        step(2);
        reset = 1'b0;
        step(10);
        evq.delete();
        rq.delete();
    endtask

    // The rising edge is first sampled on the next clock, at cycle cyc+1.
    task automatic rise_now();
        pwm_in = 1'b1;
        rq.push_back(cyc + 1);
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        repeat (n) begin
            rise_now();
            step(hi);
            pwm_in = 1'b0;
            step(lo);
        end
    endtask

    typedef struct {
        int presc;
        int hi;
        int lo;
        int exp_h;
        int exp_p;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1, 3, 7, 3, 10};
        vecs[1] = '{4, 12, 28, 3, 10};
        vecs[2] = '{0, 3, 7, 3, 10};
        vecs[3] = '{1, 5, 5, 5, 10};
        vecs[4] = '{2, 4, 6, 2, 5};
        vecs[5] = '{1, 1, 1, 1, 2};
        vecs[6] = '{3, 9, 3, 3, 4};

        // Reset state.
        reset     = 1'b1;
        pwm_in    = 1'b0;
        prescaler = 32'd1;
        step(2);
        check("rst_high_count", int'(high_count), 0);
        check("rst_period_count", int'(period_count), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_stuck_high", int'(stuck_high), 0);
        check("rst_stuck_low", int'(stuck_low), 0);

        // Periodic waveforms: four rising edges give three reports.
        for (int i = 0; i < 7; i++) begin
            do_reset(vecs[i].presc);
            wave(vecs[i].hi, vecs[i].lo, 4);
            step(12);
            check($sformatf("v%0d_nvalid", i), evq.size(), 3);
            for (int k = 0; k < evq.size(); k++) begin
                check($sformatf("v%0d_high[%0d]", i, k), evq[k].hc, vecs[i].exp_h);
                check($sformatf("v%0d_period[%0d]", i, k), evq[k].pc, vecs[i].exp_p);
                check($sformatf("v%0d_flags[%0d]", i, k), evq[k].sh + evq[k].sl, 0);
                if (vecs[i].presc <= 1 && k + 1 < rq.size()) begin
                    check($sformatf("v%0d_latency[%0d]", i, k), evq[k].cyc - rq[k+1], 2);
                end
            end
        end

        // Duty 0: one pulse then low until the timeout fires.
        do_reset(1);
        rise_now();
        step(3);
        pwm_in = 1'b0;
        for (int t = 0; t < 1100 && stuck_low !== 1'b1; t++) step(1);
        check("d0_stuck_low", int'(stuck_low), 1);
        check("d0_stuck_high", int'(stuck_high), 0);
        check("d0_nvalid", evq.size(), 1);
        if (evq.size() >= 1) begin
            check("d0_high", evq[0].hc, 0);
            check("d0_period", evq[0].pc, 0);
            check("d0_ev_stuck_low", evq[0].sl, 1);
            check("d0_timeout_cycle", evq[0].cyc - rq[0], 1024);
        end
        step(20);
        check("d0_hold_nvalid", evq.size(), 1);
        check("d0_hold_stuck_low", int'(stuck_low), 1);
        rise_now();
        step(3);
        check("d0_clear_stuck_low", int'(stuck_low), 0);
        check("d0_clear_nvalid", evq.size(), 1);
        pwm_in = 1'b0;
        step(7);
        wave(3, 7, 2);
        step(12);
        check("d0_resume_nvalid", evq.size(), 3);
        for (int k = 1; k < evq.size(); k++) begin
            check($sformatf("d0_resume_high[%0d]", k), evq[k].hc, 3);
            check($sformatf("d0_resume_period[%0d]", k), evq[k].pc, 10);
        end

        // Duty 100: held high after a rising edge.
        do_reset(1);
        rise_now();
        for (int t = 0; t < 1100 && stuck_high !== 1'b1; t++) step(1);
        check("d100_stuck_high", int'(stuck_high), 1);
        check("d100_stuck_low", int'(stuck_low), 0);
        check("d100_nvalid", evq.size(), 1);
        if (evq.size() >= 1) begin
            check("d100_high", evq[0].hc, 0);
            check("d100_period", evq[0].pc, 0);
            check("d100_ev_stuck_high", evq[0].sh, 1);
            check("d100_timeout_cycle", evq[0].cyc - rq[0], 1024);
        end
        pwm_in = 1'b0;
        step(5);
        rise_now();
        step(3);
        check("d100_clear_stuck_high", int'(stuck_high), 0);
        check("d100_clear_nvalid", evq.size(), 1);

        // Reset mid-measurement with the input high.
        do_reset(1);
        wave(3, 7, 2);
        rise_now();
        step(2);
        check("rm_pre_high", int'(high_count), 3);
        reset = 1'b1;
        step(1);
        check("rm_high_count", int'(high_count), 0);
        check("rm_period_count", int'(period_count), 0);
        check("rm_valid", int'(valid), 0);
        check("rm_stuck", int'(stuck_high) + int'(stuck_low), 0);
        reset = 1'b0;
        evq.delete();
        rq.delete();
        step(20);
        check("rm_no_rise_while_high", evq.size(), 0);
        pwm_in = 1'b0;
        step(7);
        wave(3, 7, 2);
        step(12);
        check("rm_nvalid", evq.size(), 1);
        if (evq.size() >= 1) begin
            check("rm_high", evq[0].hc, 3);
            check("rm_period", evq[0].pc, 10);
            check("rm_latency", evq[0].cyc - rq[1], 2);
        end

        // Lowering the prescaler from 100 to 2 with the counter at 50.
        reset     = 1'b1;
        pwm_in    = 1'b0;
        prescaler = 32'd100;
        step(2);
        reset = 1'b0;
        step(50);
        check("pc_tick_before", int'(dut.tick), 0);
        prescaler = 32'd2;
        #1;
        check("pc_tick_now", int'(dut.tick), 1);
        for (int k = 0; k < 6; k++) begin
            step(1);
            check($sformatf("pc_tick[%0d]", k), int'(dut.tick), k % 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
